// File: rtl/ps2_kbd_receiver.sv
// PS/2 keyboard receiver: synchronises the raw PS/2 lines, deserialises and checks
// 11-bit frames, and queues good scancodes for the I/O bus keyboard port.
module ps2_kbd_receiver #(
    parameter int FIFO_DEPTH = 8,
    parameter int TIMEOUT    = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    input  logic       kbd_read,
    output logic       kbd_ready,
    output logic [7:0] scancode,
    output logic       overflow,
    output logic       frame_err
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam int TO_W  = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RECV  = 2'd1,
        CHECK = 2'd2
    } state_t;

    // Line synchronisers; reset to the idle-high level of the PS/2 bus.
    logic clk_meta;
    logic clk_sync;
    logic clk_prev;
    logic data_meta;
    logic data_sync;
    logic fall;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_meta  <= 1'b1;
            clk_sync  <= 1'b1;
            clk_prev  <= 1'b1;
            data_meta <= 1'b1;
            data_sync <= 1'b1;
        end else begin
            clk_meta  <= ps2_clk;
            clk_sync  <= clk_meta;
            clk_prev  <= clk_sync;
            data_meta <= ps2_data;
            data_sync <= data_meta;
        end
    end

    assign fall = clk_prev & ~clk_sync;

    // Frame receiver FSM
    state_t            state;
    state_t            state_next;
    logic [3:0]        bit_cnt;
    logic [3:0]        bit_cnt_next;
    logic [9:0]        shift_reg;
    logic [9:0]        shift_next;
    logic [TO_W-1:0]   to_cnt;
    logic [TO_W-1:0]   to_next;
    logic              frame_err_next;
    logic              frame_good;
    logic              frame_ok;

    // shift_reg holds bits 1..10 once complete: [7:0] data, [8] parity, [9] stop.
    assign frame_ok = shift_reg[9] & (^shift_reg[8:0]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            bit_cnt   <= 4'd0;
            shift_reg <= 10'd0;
            to_cnt    <= '0;
            frame_err <= 1'b0;
        end else begin
            state     <= state_next;
            bit_cnt   <= bit_cnt_next;
            shift_reg <= shift_next;
            to_cnt    <= to_next;
            frame_err <= frame_err_next;
        end
    end

    always_comb begin
        state_next     = state;
        bit_cnt_next   = bit_cnt;
        shift_next     = shift_reg;
        to_next        = to_cnt;
        frame_err_next = 1'b0;
        frame_good     = 1'b0;
        case (state)
            IDLE: begin
                to_next = '0;
                if (fall && !data_sync) begin
                    state_next   = RECV;
                    bit_cnt_next = 4'd1;
                end
            end
            RECV: begin
                if (fall) begin
                    shift_next   = {data_sync, shift_reg[9:1]};
                    bit_cnt_next = bit_cnt + 4'd1;
                    to_next      = '0;
                    if (bit_cnt == 4'd10) begin
                        state_next = CHECK;
                    end
                end else if (to_cnt == TO_W'(TIMEOUT - 1)) begin
                    // Keyboard stalled mid-frame: drop the partial frame.
                    state_next     = IDLE;
                    bit_cnt_next   = 4'd0;
                    to_next        = '0;
                    frame_err_next = 1'b1;
                end else begin
                    to_next = to_cnt + 1'b1;
                end
            end
            CHECK: begin
                state_next   = IDLE;
                bit_cnt_next = 4'd0;
                if (frame_ok) begin
                    frame_good = 1'b1;
                end else begin
                    frame_err_next = 1'b1;
                end
            end
            default: begin
                state_next   = IDLE;
                bit_cnt_next = 4'd0;
            end
        endcase
    end

    // Bus handshake: kbd_ready is valid; a rising kbd_read is the accept that pops the
    // head. ack_pending holds kbd_ready low until kbd_read is seen low, so exactly one
    // entry is consumed per bus read.
    logic [7:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             read_prev;
    logic             ack_pending;
    logic             empty;
    logic             full;
    logic             push;
    logic             pop;

    assign empty = (count == '0);
    assign full  = (count == CNT_W'(FIFO_DEPTH));
    assign pop   = kbd_read & ~read_prev & ~empty;
    // A pop in the same cycle frees a slot, so a full FIFO can still accept.
    assign push  = frame_good & (~full | pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            read_prev   <= 1'b0;
            ack_pending <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            read_prev <= kbd_read;
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (pop) begin
                ack_pending <= 1'b1;
            end else if (!kbd_read) begin
                ack_pending <= 1'b0;
            end
            if (frame_good && full && !pop) begin
                overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= shift_reg[7:0];
        end
    end

    assign kbd_ready = ~empty & ~ack_pending;
    assign scancode  = empty ? 8'h00 : mem[rd_ptr];

endmodule

// File: doc/ps2_kbd_receiver.md
Name: ps2_kbd_receiver

Overview:
PS/2 keyboard receiver feeding the I/O bus keyboard port (0xf0000014 scancode, 0xf0000018 ready). Synchronises the raw PS/2 clock/data lines, deserialises 11-bit frames, checks them, and buffers good scancodes in a small FIFO. It presents the FIFO head as scancode/kbd_ready and pops one entry per kbd_read handshake. The I/O bus raises kbd_read after a CPU read of 0xf0000014 and lowers it only after kbd_ready falls.

Parameters:
FIFO_DEPTH, 8, scancode buffer entries; power of 2, minimum 2
TIMEOUT, 50000, clk cycles without a PS/2 falling edge before a partial frame is discarded

Ports:
clk  input  1  system clock; all logic on posedge
rst  input  1  asynchronous, active-high reset
ps2_clk  input  1  raw PS/2 clock from the pin, asynchronous
ps2_data  input  1  raw PS/2 data from the pin, asynchronous
kbd_read  input  1  level acknowledge from the I/O bus
kbd_ready  output  1  FIFO head valid and not yet acknowledged
scancode  output  8  FIFO head byte; 0 when FIFO empty
overflow  output  1  sticky: a good frame was dropped because the FIFO was full
frame_err  output  1  one-cycle pulse on a parity/start/stop error or a timeout abort

Behaviour:
- Reset, asynchronous: FIFO empty, kbd_ready=0, scancode=0, overflow=0, frame_err=0, bit counter=0, state IDLE, synchronisers=1, handshake latch clear.
- Sync: 2-flop synchronisers on ps2_clk and ps2_data. A falling edge is prev_sync_clk=1 and sync_clk=0. Data is sampled from sync_data in that same cycle.
- Frame: bit0 start (must be 0), bits1-8 data LSB first, bit9 odd parity (total ones over data+parity is odd), bit10 stop (must be 1).
- States:
  - IDLE: a falling edge with data=0 goes to RECV, bit count=1. A falling edge with data=1 is ignored.
  - RECV: each falling edge shifts one bit and increments the count. After the bit10 edge, go to CHECK.
  - CHECK (one cycle), then IDLE:
    - Frame good, FIFO not full: push.
    - Frame good, FIFO full: drop it, set overflow.
    - Frame bad: drop it, pulse frame_err.
- Timeout: a cycle counter clears on every falling edge and counts only in RECV. When it reaches TIMEOUT, discard the partial frame, pulse frame_err, return to IDLE.
- Push latency: kbd_ready rises 1 cycle after CHECK when the FIFO was previously empty. Total from the stop-bit falling edge on the sync output to kbd_ready=1 is 2 clk.
- Handshake:
  - kbd_ready = !empty && !ack_pending.
  - Rising edge of kbd_read (registered previous value 0, current 1) while !empty: pop exactly one entry and set ack_pending.
  - ack_pending clears when kbd_read is seen low. kbd_ready then re-asserts the next cycle if entries remain.
  - This guarantees kbd_ready drops after each pop, so the bus releases kbd_read; one entry per CPU read.
- A kbd_read rise when the FIFO is empty has no effect.
- scancode is valid only while kbd_ready=1. It holds the head and changes only on pop or on a push into an empty FIFO.
- Simultaneous push and pop: both occur and the count is unchanged. A push is never refused while a pop is freeing the last slot.
- FIFO pointers are log2(FIFO_DEPTH) bits and wrap naturally. Full/empty use a count register 0..FIFO_DEPTH.
- overflow clears only by reset.
- PS/2 lines are never driven; the block is receive-only.

Test Plan:
- Frame for 0x1C (start 0; data 0,0,1,1,1,0,0,0; parity 0; stop 1) -> kbd_ready=1 and scancode=8'h1C 2 clk after the last sync falling edge; frame_err stays 0.
- Same frame with parity bit 1 -> no push, kbd_ready stays 0, frame_err one 1-cycle pulse.
- Push 0x1C, 0xF0, 0x1C; emulate the bus (kbd_read=1 while ready, drop when ready=0):
  - kbd_ready toggles low then high between reads.
  - Reads return 8'h1C, 8'hF0, 8'h1C, then kbd_ready=0.
- With TIMEOUT=100: send 5 bits then stop toggling -> frame_err pulse at cycle 100 after the last edge; a following full 0x29 frame is received correctly.
- Send 9 good frames 0x01..0x09 with FIFO_DEPTH=8 and no reads -> overflow=1; reads return 0x01..0x08 only; the 9th frame is lost.
- Assert rst mid-frame, after 4 bits with 2 entries queued -> immediate kbd_ready=0, scancode=0, overflow=0; the next complete frame 0x5A is received as the only entry.
